// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Selects the next PC and fetches one instruction at a time for decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_kill;
  logic            r_instr_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;

  state_t          w_state_nxt;
  logic            w_kill_nxt;
  logic            w_valid_nxt;
  logic            w_capture;
  logic            w_req;
  logic [XLEN-1:0] w_next_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_REQ;
      r_kill        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_kill        <= w_kill_nxt;
      r_instr_valid <= w_valid_nxt;
      if (w_capture) begin
        r_instr    <= imem_rdata_i;
        r_instr_pc <= pc_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    w_valid_nxt = r_instr_valid;
    w_capture   = 1'b0;
    w_req       = 1'b0;
    w_next_pc   = pc_i;

    case (r_state)
      S_REQ: begin
        w_req = 1'b1;
        // A redirect alongside the grant means the accepted fetch is already stale.
        if (imem_gnt_i) begin
          w_state_nxt = S_WAIT;
          w_kill_nxt  = redirect_i;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          w_kill_nxt = 1'b0;
          if (r_kill || redirect_i) begin
            w_state_nxt = S_REQ;
          end else begin
            w_capture   = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_OUT;
          end
        end else if (redirect_i) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_i || instr_ready_i) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
          if (!redirect_i) begin
            w_next_pc = pc_i + XLEN'(4);
          end
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    if (redirect_i) begin
      w_next_pc = {redirect_target_i[XLEN-1:2], 2'b00};
    end

    // The PC register loads every edge, so reset must steer it too.
    if (reset) begin
      w_next_pc = RESET_PC[XLEN-1:0];
      w_req     = 1'b0;
    end
  end

  assign next_pc_o     = w_next_pc;
  assign imem_req_o    = w_req;
  assign imem_addr_o   = pc_i;
  assign instr_valid_o = r_instr_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed self-checking bench for fetch_sequencer with a PC register model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int tests;
  int errors;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_i              (pc),
    .next_pc_o         (next_pc_o),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .instr_valid_o     (instr_valid_o),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .instr_ready_i     (instr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register without enable: loads NextPC on every edge.
  always @(posedge clk) pc <= next_pc_o;

  task automatic clear_inputs();
    imem_gnt_i        = 1'b0;
    imem_rvalid_i     = 1'b0;
    imem_rdata_i      = 32'h0;
    redirect_i        = 1'b0;
    redirect_target_i = 32'h0;
    instr_ready_i     = 1'b0;
  endtask

  // Inputs are changed just after a rising edge; checks happen at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %h exp %h", imem_req_o, 1'b0); end
    tests++; if (next_pc_o !== 32'h0) begin errors++; $display("FAIL reset_next_pc: got %h exp %h", next_pc_o, 32'h0); end
    tests++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h exp %h", instr_valid_o, 1'b0); end
    tests++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp %h", instr_o, 32'h0); end
    tests++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h exp %h", instr_pc_o, 32'h0); end
  endtask

  task automatic test_basic_fetch();
    imem_gnt_i = 1'b1;
    @(negedge clk);
    tests++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL basic_req: got %h exp %h", imem_req_o, 1'b1); end
    tests++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h exp %h", imem_addr_o, 32'h0); end
    tests++; if (next_pc_o !== 32'h0) begin errors++; $display("FAIL basic_hold_req: got %h exp %h", next_pc_o, 32'h0); end
    next_cycle();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
    @(negedge clk);
    tests++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL basic_wait_req: got %h exp %h", imem_req_o, 1'b0); end
    tests++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL basic_wait_valid: got %h exp %h", instr_valid_o, 1'b0); end
    next_cycle();
    instr_ready_i = 1'b1;
    @(negedge clk);
    tests++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %h exp %h", instr_valid_o, 1'b1); end
    tests++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr: got %h exp %h", instr_o, 32'h0050_0093); end
    tests++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL basic_instr_pc: got %h exp %h", instr_pc_o, 32'h0); end
    tests++; if (next_pc_o !== 32'h4) begin errors++; $display("FAIL basic_pc_plus4: got %h exp %h", next_pc_o, 32'h4); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_clear: got %h exp %h", instr_valid_o, 1'b0); end
    tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errors++; $display("FAIL basic_next_req: got req=%h addr=%h exp req=1 addr=00000004", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_gnt_delay();
    for (int i = 0; i < 3; i++) begin
      imem_gnt_i = (i == 2);
      @(negedge clk);
      tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errors++; $display("FAIL gnt_delay_req[%0d]: got req=%h addr=%h exp req=1 addr=00000004", i, imem_req_o, imem_addr_o); end
      tests++; if (next_pc_o !== 32'h4) begin errors++; $display("FAIL gnt_delay_hold[%0d]: got %h exp %h", i, next_pc_o, 32'h4); end
      next_cycle();
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0010_0113;
    @(negedge clk);
    tests++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL gnt_delay_wait_req: got %h exp %h", imem_req_o, 1'b0); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0010_0113 || instr_pc_o !== 32'h4) begin errors++; $display("FAIL bp_stable[%0d]: got v=%h i=%h pc=%h exp v=1 i=00100113 pc=00000004", i, instr_valid_o, instr_o, instr_pc_o); end
      tests++; if (next_pc_o !== 32'h4 || imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got next=%h req=%h exp next=00000004 req=0", i, next_pc_o, imem_req_o); end
      next_cycle();
    end
    instr_ready_i = 1'b1;
    @(negedge clk);
    tests++; if (next_pc_o !== 32'h8) begin errors++; $display("FAIL bp_release: got %h exp %h", next_pc_o, 32'h8); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_valid_o !== 1'b0 || imem_addr_o !== 32'h8 || next_pc_o !== 32'h8) begin errors++; $display("FAIL bp_once: got v=%h addr=%h next=%h exp v=0 addr=00000008 next=00000008", instr_valid_o, imem_addr_o, next_pc_o); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt_i = 1'b1;
    next_cycle();
    redirect_i = 1'b1; redirect_target_i = 32'h1000_0000;
    @(negedge clk);
    tests++; if (next_pc_o !== 32'h1000_0000) begin errors++; $display("FAIL rw_next_pc: got %h exp %h", next_pc_o, 32'h1000_0000); end
    next_cycle();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rw_valid_during: got %h exp %h", instr_valid_o, 1'b0); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rw_discard: got %h exp %h", instr_valid_o, 1'b0); end
    tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1000_0000) begin errors++; $display("FAIL rw_req: got req=%h addr=%h exp req=1 addr=10000000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_redirect_out();
    imem_gnt_i = 1'b1;
    next_cycle();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    next_cycle();
    redirect_i = 1'b1; redirect_target_i = 32'h1000_0006; instr_ready_i = 1'b1;
    @(negedge clk);
    tests++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h1000_0000) begin errors++; $display("FAIL ro_valid: got v=%h pc=%h exp v=1 pc=10000000", instr_valid_o, instr_pc_o); end
    tests++; if (next_pc_o !== 32'h1000_0004) begin errors++; $display("FAIL ro_next_pc: got %h exp %h", next_pc_o, 32'h1000_0004); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL ro_valid_clear: got %h exp %h", instr_valid_o, 1'b0); end
    tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1000_0004) begin errors++; $display("FAIL ro_req: got req=%h addr=%h exp req=1 addr=10000004", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    @(negedge clk);
    tests++; if (next_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect: got %h exp %h", next_pc_o, 32'hFFFF_FFFC); end
    next_cycle();
    imem_gnt_i = 1'b1;
    @(negedge clk);
    tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got req=%h addr=%h exp req=1 addr=fffffffc", imem_req_o, imem_addr_o); end
    next_cycle();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    next_cycle();
    instr_ready_i = 1'b1;
    @(negedge clk);
    tests++; if (instr_pc_o !== 32'hFFFF_FFFC || instr_o !== 32'h1234_5678) begin errors++; $display("FAIL wrap_instr: got pc=%h i=%h exp pc=fffffffc i=12345678", instr_pc_o, instr_o); end
    tests++; if (next_pc_o !== 32'h0) begin errors++; $display("FAIL wrap_next_pc: got %h exp %h", next_pc_o, 32'h0); end
    next_cycle();
  endtask

  task automatic test_redirect_req_gnt();
    imem_gnt_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h0000_0020;
    @(negedge clk);
    tests++; if (next_pc_o !== 32'h20) begin errors++; $display("FAIL rg_next_pc: got %h exp %h", next_pc_o, 32'h20); end
    next_cycle();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0BAD;
    @(negedge clk);
    tests++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rg_wait: got %h exp %h", imem_req_o, 1'b0); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h20) begin errors++; $display("FAIL rg_killed: got v=%h req=%h addr=%h exp v=0 req=1 addr=00000020", instr_valid_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_reset_mid();
    imem_gnt_i = 1'b1;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    tests++; if (next_pc_o !== 32'h0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL rm_reset: got next=%h req=%h exp next=00000000 req=0", next_pc_o, imem_req_o); end
    next_cycle();
    reset = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL rm_req: got req=%h addr=%h exp req=1 addr=00000000", imem_req_o, imem_addr_o); end
    next_cycle();
    @(negedge clk);
    tests++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin errors++; $display("FAIL rm_stray: got v=%h req=%h exp v=0 req=1", instr_valid_o, imem_req_o); end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    test_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    test_basic_fetch();
    test_gnt_delay();
    test_backpressure();
    test_redirect_wait();
    test_redirect_out();
    test_wrap();
    test_redirect_req_gnt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
